// File: rtl/pw_programmer.sv
// Combination programmer for the password lock: takes a new combination, requires
// an identical confirmation pass, then commits it to the stored code register.
module pw_programmer #(
    parameter int unsigned               DIGITS       = 5,
    parameter logic [4*DIGITS-1:0]       DEFAULT_CODE = 20'h12345
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         prog,
    input  logic                         abort,
    input  logic [9:0]                   comb_in,
    output logic [4*DIGITS-1:0]          code,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic [3:0]                   last_digit,
    output logic [4:0]                   states
);

    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] LastIdx = CW'(DIGITS - 1);

    // One-hot encoding doubles as the LED vector.
    typedef enum logic [4:0] {
        StIdle   = 5'b00001,
        StEnter1 = 5'b00010,
        StEnter2 = 5'b00100,
        StCommit = 5'b01000,
        StFail   = 5'b10000
    } state_e;

    state_e                state_q;
    logic [4*DIGITS-1:0]   code_q;
    logic [4*DIGITS-1:0]   buf_q;
    logic [CW-1:0]         count_q;
    logic                  mm_q;
    logic [3:0]            last_digit_q;

    logic                  digit_multi;
    logic                  digit_valid;
    logic [3:0]            digit_val;
    logic [3:0]            cur_nibble;
    logic [4*DIGITS-1:0]   buf_wr;
    logic                  nibble_mm;

    // Decode the switch pulses and address the buffer nibble selected by count.
    always_comb begin
        digit_multi = |(comb_in & (comb_in - 10'd1));
        digit_valid = (comb_in != 10'd0) && !digit_multi;
        digit_val   = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (comb_in[i]) digit_val = 4'(i);
        end
        cur_nibble = 4'd0;
        buf_wr     = buf_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (count_q == CW'(i)) begin
                // First digit lands in the most significant nibble.
                cur_nibble                     = buf_q[4*(DIGITS-1-i) +: 4];
                buf_wr[4*(DIGITS-1-i) +: 4]    = digit_val;
            end
        end
        nibble_mm = (cur_nibble != digit_val);
    end

    // Programming FSM with its datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            code_q       <= DEFAULT_CODE;
            buf_q        <= '0;
            count_q      <= '0;
            mm_q         <= 1'b0;
            last_digit_q <= 4'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (prog) begin
                        state_q <= StEnter1;
                        count_q <= '0;
                        mm_q    <= 1'b0;
                    end
                end
                StEnter1: begin
                    if (abort) begin
                        state_q <= StIdle;
                        count_q <= '0;
                        mm_q    <= 1'b0;
                    end else if (digit_multi) begin
                        state_q <= StFail;
                    end else if (digit_valid) begin
                        buf_q        <= buf_wr;
                        last_digit_q <= digit_val;
                        if (count_q == LastIdx) begin
                            state_q <= StEnter2;
                            count_q <= '0;
                            mm_q    <= 1'b0;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StEnter2: begin
                    if (abort) begin
                        state_q <= StIdle;
                        count_q <= '0;
                        mm_q    <= 1'b0;
                    end else if (digit_multi) begin
                        state_q <= StFail;
                    end else if (digit_valid) begin
                        last_digit_q <= digit_val;
                        count_q      <= count_q + 1'b1;
                        mm_q         <= mm_q | nibble_mm;
                        if (count_q == LastIdx) begin
                            // Include the current digit in the verdict.
                            if (mm_q || nibble_mm) begin
                                state_q <= StFail;
                            end else begin
                                state_q <= StCommit;
                                code_q  <= buf_q;
                            end
                        end
                    end
                end
                StCommit, StFail: begin
                    state_q <= StIdle;
                    count_q <= '0;
                    mm_q    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    count_q <= '0;
                    mm_q    <= 1'b0;
                end
            endcase
        end
    end

    // Status outputs decoded straight from the state register.
    always_comb begin
        states     = state_q;
        busy       = (state_q != StIdle);
        done       = (state_q == StCommit);
        error      = (state_q == StFail);
        code       = code_q;
        count      = count_q;
        last_digit = last_digit_q;
    end

endmodule

// File: tb/tb_pw_programmer.sv
// Self-checking bench for pw_programmer: scoreboard of expected done/error pulses
// plus inline state checks per scenario.
module tb_pw_programmer;

    logic        clk;
    logic        rst_n;
    logic        prog;
    logic        abort;
    logic [9:0]  comb_in;
    logic [19:0] code;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  count;
    logic [3:0]  last_digit;
    logic [4:0]  states;

    typedef struct packed {
        logic        done;
        logic        err;
        logic [19:0] code;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    pw_programmer #(
        .DIGITS       (5),
        .DEFAULT_CODE (20'h12345)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .prog       (prog),
        .abort      (abort),
        .comb_in    (comb_in),
        .code       (code),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .count      (count),
        .last_digit (last_digit),
        .states     (states)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every done/error cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && (done || error)) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: done=%b error=%b code=%h, required none", done,
                         error, code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (done !== e.done || error !== e.err || code !== e.code) begin
                    miscompares++;
                    $display("FAIL pulse: done=%b error=%b code=%h, required done=%b error=%b code=%h",
                             done, error, code, e.done, e.err, e.code);
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive one pulse for one cycle; returns at the negedge after it was sampled.
    task automatic pulse_prog();
        @(negedge clk) prog = 1'b1;
        @(negedge clk) prog = 1'b0;
    endtask

    task automatic press(input int d);
        logic [9:0] v;
        v = 10'd1 << d;
        @(negedge clk) comb_in = v;
        @(negedge clk) comb_in = 10'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog = 1'b0; abort = 1'b0; comb_in = 10'd0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        vectors++;
        if (code !== 20'h12345 || states !== 5'b00001 || busy !== 1'b0 || done !== 1'b0 ||
            error !== 1'b0 || count !== 3'd0 || last_digit !== 4'd0) begin
            miscompares++;
            $display("FAIL reset: code=%h states=%b busy=%b done=%b error=%b count=%0d ld=%0d, required 12345 00001 0 0 0 0 0",
                     code, states, busy, done, error, count, last_digit);
        end
    endtask

    task automatic test_program();
        int digs[5] = '{9, 8, 7, 6, 5};
        pulse_prog();
        vectors++;
        if (states !== 5'b00010 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL prog_enter1: states=%b busy=%b, required 00010 1", states, busy);
        end
        for (int i = 0; i < 5; i++) begin press(digs[i]); idle(1); end
        vectors++;
        if (states !== 5'b00100 || count !== 3'd0 || last_digit !== 4'd5) begin
            miscompares++;
            $display("FAIL prog_enter2: states=%b count=%0d ld=%0d, required 00100 0 5", states,
                     count, last_digit);
        end
        for (int i = 0; i < 4; i++) begin press(digs[i]); idle(1); end
        vectors++;
        if (count !== 3'd4 || code !== 20'h12345) begin
            miscompares++;
            $display("FAIL prog_confirm_count: count=%0d code=%h, required 4 12345", count, code);
        end
        sb.push_back('{done: 1'b1, err: 1'b0, code: 20'h98765});
        press(digs[4]);
        vectors++;
        if (states !== 5'b01000 || done !== 1'b1 || code !== 20'h98765) begin
            miscompares++;
            $display("FAIL prog_commit: states=%b done=%b code=%h, required 01000 1 98765", states,
                     done, code);
        end
        idle(1);
        vectors++;
        if (states !== 5'b00001 || done !== 1'b0 || busy !== 1'b0 || code !== 20'h98765 ||
            last_digit !== 4'd5) begin
            miscompares++;
            $display("FAIL prog_idle: states=%b done=%b busy=%b code=%h ld=%0d, required 00001 0 0 98765 5",
                     states, done, busy, code, last_digit);
        end
    endtask

    task automatic test_mismatch();
        int a[5] = '{1, 1, 2, 2, 3};
        int b[5] = '{1, 1, 2, 2, 4};
        pulse_prog();
        for (int i = 0; i < 5; i++) begin press(a[i]); idle(1); end
        for (int i = 0; i < 4; i++) begin press(b[i]); idle(1); end
        sb.push_back('{done: 1'b0, err: 1'b1, code: 20'h98765});
        press(b[4]);
        vectors++;
        if (states !== 5'b10000 || error !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mismatch_fail: states=%b error=%b done=%b, required 10000 1 0", states,
                     error, done);
        end
        idle(1);
        vectors++;
        if (states !== 5'b00001 || count !== 3'd0 || code !== 20'h98765 || error !== 1'b0) begin
            miscompares++;
            $display("FAIL mismatch_idle: states=%b count=%0d code=%h error=%b, required 00001 0 98765 0",
                     states, count, code, error);
        end
    endtask

    task automatic test_multi();
        pulse_prog();
        press(1); idle(1);
        press(2); idle(1);
        vectors++;
        if (count !== 3'd2 || last_digit !== 4'd2) begin
            miscompares++;
            $display("FAIL multi_pre: count=%0d ld=%0d, required 2 2", count, last_digit);
        end
        sb.push_back('{done: 1'b0, err: 1'b1, code: 20'h98765});
        @(negedge clk) comb_in = 10'b0000000011;
        @(negedge clk) comb_in = 10'd0;
        vectors++;
        if (states !== 5'b10000 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_fail: states=%b error=%b, required 10000 1", states, error);
        end
        idle(1);
        vectors++;
        if (states !== 5'b00001 || code !== 20'h98765) begin
            miscompares++;
            $display("FAIL multi_idle: states=%b code=%h, required 00001 98765", states, code);
        end
    endtask

    task automatic test_abort();
        pulse_prog();
        press(1); idle(1);
        press(2); idle(1);
        press(3); idle(1);
        @(negedge clk) begin comb_in = 10'd1 << 7; abort = 1'b1; end
        @(negedge clk) begin comb_in = 10'd0; abort = 1'b0; end
        vectors++;
        if (states !== 5'b00001 || count !== 3'd0 || last_digit !== 4'd3 || busy !== 1'b0 ||
            code !== 20'h98765) begin
            miscompares++;
            $display("FAIL abort: states=%b count=%0d ld=%0d busy=%b code=%h, required 00001 0 3 0 98765",
                     states, count, last_digit, busy, code);
        end
        idle(3);
    endtask

    task automatic test_async_reset();
        int digs[5] = '{9, 8, 7, 6, 5};
        pulse_prog();
        for (int i = 0; i < 5; i++) begin press(digs[i]); idle(1); end
        press(9);
        vectors++;
        if (states !== 5'b00100 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL rst_pre: states=%b count=%0d, required 00100 1", states, count);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (states !== 5'b00001 || code !== 20'h12345 || busy !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_async: states=%b code=%h busy=%b count=%0d, required 00001 12345 0 0",
                     states, code, busy, count);
        end
        @(negedge clk) rst_n = 1'b1;
        pulse_prog();
        vectors++;
        if (states !== 5'b00010 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_restart: states=%b count=%0d, required 00010 0", states, count);
        end
        press(4);
        vectors++;
        if (count !== 3'd1 || last_digit !== 4'd4) begin
            miscompares++;
            $display("FAIL rst_digit: count=%0d ld=%0d, required 1 4", count, last_digit);
        end
        @(negedge clk) abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_program();
        test_mismatch();
        test_multi();
        test_abort();
        test_async_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulse: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pw_programmer.md
# pw_programmer

Combination-programming block for the password lock. It is the writer side of the stored combination: it accepts a new combination from the one-shot-conditioned switch pulses, requires the same combination to be entered a second time as confirmation, and then commits it to the code register that the checking FSM compares against. It runs on the divided lock clock, alongside the checker.

## Interface
Parameters:
- DIGITS, default 5: number of decimal digits in a combination.
- DEFAULT_CODE, default 20'h12345: BCD combination loaded at reset. The first digit is the most significant nibble. Width is 4*DIGITS.

Ports:
- clk, input, 1: single clock (divided lock clock). All logic is on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- prog, input, 1: one-cycle pulse that requests programming mode.
- abort, input, 1: one-cycle pulse that cancels programming.
- comb_in, input, 10: one-shot switch pulses. Bit i set means digit i was pressed.
- code, output, 4*DIGITS: stored combination, BCD, first digit in the MSB nibble.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a new code is committed.
- error, output, 1: one-cycle pulse when programming fails.
- count, output, $clog2(DIGITS+1): number of digits accepted in the current pass.
- last_digit, output, 4: BCD value of the most recently accepted digit, for the display.
- states, output, 5: one-hot state for the LEDs. Bit order is IDLE, ENTER1, ENTER2, COMMIT, FAIL (bit 0 = IDLE).

## Operation
- States:
  - IDLE: prog → ENTER1. comb_in is ignored.
  - ENTER1: each valid digit is shifted into buf at the nibble selected by count, and count increments. When the DIGITS-th digit is accepted → ENTER2, count clears.
  - ENTER2: each valid digit is compared with buf at nibble position count. Any mismatch sets the sticky flag mm, and count increments. On the DIGITS-th digit: → COMMIT if no mismatch (including the current digit), otherwise → FAIL.
  - COMMIT: lasts 1 cycle, then → IDLE.
  - FAIL: lasts 1 cycle, then → IDLE.
- Valid digit: comb_in has exactly one bit set. The digit value is that bit's index (0–9).
- comb_in == 0: no action.
- More than one bit set in ENTER1 or ENTER2: → FAIL.
- abort in ENTER1 or ENTER2: → IDLE. abort beats a digit presented in the same cycle. code is unchanged, no error pulse, count clears.
- prog outside IDLE: ignored.
- code loads buf on the edge that enters COMMIT. In every other case it holds.
- done = (state == COMMIT). error = (state == FAIL).
- count and mm clear on every entry to ENTER1, on every entry to ENTER2, and on return to IDLE.
- last_digit updates on every accepted digit in ENTER1 or ENTER2.
- Reset values:
  - state IDLE, states = 5'b00001
  - code = DEFAULT_CODE
  - buf = 0, count = 0, mm = 0, last_digit = 0
  - busy = 0, done = 0, error = 0
- The code is volatile: reset in any state (including mid-programming) restores DEFAULT_CODE immediately and asynchronously.

## Timing
- prog sampled at edge N → busy and the ENTER1 LED are high after edge N.
- A digit pulse sampled at an edge updates count and last_digit from that edge.
- Final confirm digit at edge N:
  - code holds the new value after edge N.
  - done is high for exactly the cycle between edges N and N+1.
  - busy is low after edge N+1.
- Failure follows the same timing as commit, with error in place of done.
- A digit pulse in the COMMIT or FAIL cycle is ignored.
- Latency from first prog to done is 2*DIGITS + 1 accepted pulses plus 1 cycle. There is no timeout.

## Test plan
1. Release rst. Required: code=20'h12345, states=5'b00001, busy=0, done=0, error=0.
2. prog, then digits 9,8,7,6,5, then 9,8,7,6,5, with idle cycles between pulses. Required: states walks ENTER1 → ENTER2 → COMMIT → IDLE, done high for exactly 1 cycle, code=20'h98765 from that cycle on, last_digit=5.
3. prog, then 1,1,2,2,3, then confirm 1,1,2,2,4. Required: error high for 1 cycle, no done pulse, code unchanged (20'h98765 after scenario 2), count=0 in IDLE.
4. In ENTER1 after two digits, drive comb_in=10'b0000000011. Required: FAIL for 1 cycle, error pulse, code unchanged.
5. In ENTER1 after 3 digits, assert abort in the same cycle as digit 7. Required: IDLE on the next edge, count=0, last_digit unchanged from the previous digit, no error or done pulse.
6. Assert rst low mid-cycle in ENTER2 after a committed code of 20'h98765. Required: immediately states=5'b00001, code=20'h12345, busy=0. After release, prog restarts cleanly at count=0.
